// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data-memory responder: access size,
// FSM state and the store byte-lane mask.
package mem_resp_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_e;

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [LANES-1:0] byte_mask(input size_e size, input logic [1:0] addr_lo);
        logic [LANES-1:0] m;
        m = '0;
        case (size)
            SIZE_B:  m = LANES'(4'b0001 << addr_lo);
            SIZE_H:  m = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic access_err(input size_e size, input logic [1:0] addr_lo);
        logic e;
        e = 1'b0;
        case (size)
            SIZE_H:  e = addr_lo[0];
            SIZE_W:  e = (addr_lo != 2'b00);
            SIZE_RSV: e = 1'b1;
            default: e = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a RAM word and sign- or zero-extends it.
module load_extend
    import mem_resp_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = '0;
        case (i_size)
            SIZE_B:  o_data = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SIZE_H:  o_data = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            SIZE_W:  o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder in front of a word-organised RAM,
// with a fixed request-to-response latency.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 1 << WORD_AW;

    state_e                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

    logic                  r_we;
    size_e                 r_size;
    logic                  r_uns;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_req_ready, r_rsp_valid, r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept, w_exec, w_err;
    logic                  w_req_ready_nxt, w_rsp_valid_nxt;
    logic [LANES-1:0]      w_mask;
    logic [WORD_AW-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_wlanes, w_ld_word, w_ld_data;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_idx     = r_addr[ADDR_WIDTH-1:2];
    assign w_err     = access_err(r_size, r_addr[1:0]);
    assign w_mask    = byte_mask(r_size, r_addr[1:0]);
    assign w_ld_word = r_mem[w_idx];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; the counter spans the full latency so the response
    // appears LATENCY edges after acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_W'(LATENCY);
                end
            end
            BUSY: begin
                if (w_exec) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept        = (r_state == IDLE) && req_valid;
        w_exec          = (r_state == BUSY) && (r_cnt == CNT_W'(1));
        w_req_ready_nxt = (w_state_nxt == IDLE);
        w_rsp_valid_nxt = (w_state_nxt == RESP);
    end

    always_comb begin
        w_wlanes = r_wdata;
        case (r_size)
            SIZE_B:  w_wlanes = {4{r_wdata[7:0]}};
            SIZE_H:  w_wlanes = {2{r_wdata[15:0]}};
            default: w_wlanes = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_size  <= SIZE_B;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_size  <= size_e'(req_size);
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            if (w_exec) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_we) ? '0 : w_ld_data;
            end
        end
    end

    // RAM contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_exec && r_we && !w_err) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (w_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .i_word     (w_ld_word),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ld_data)
    );

endmodule
